// File: rtl/mul_unit.sv
// mul_unit -- iterative RV64M multiplier (MUL, MULH, MULHSU, MULHU).
// Radix-2 shift-add over WIDTH cycles, plus one sign-fix cycle and a
// one-cycle done state. Fixed latency: start sampled at edge T, done at T+66.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   start   request a multiply (sampled only when not busy)
//   kill    synchronous abort; overrides start
//   op      funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a, b    rs1 / rs2 operands, captured with an accepted start
//   busy    high during RUN and FIX
//   done    one-cycle pulse, result newly valid
//   result  registered result, held until the next completion
module mul_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  // The architectural accumulator is one bit wider, but its top bit is
  // always zero after the shift, so only the low 2*WIDTH bits are stored.
  // The add carry lives in the 65-bit sum and lands in acc[127] on shift.
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic               low_sel;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod;

  assign accept = start && !kill && (state == IDLE || state == DONE);

  // a is signed for MULH/MULHSU, b only for MULH. The magnitude of the most
  // negative value is itself, read as unsigned 2^(WIDTH-1).
  assign a_neg = (op == 2'b01 || op == 2'b10) && a[WIDTH-1];
  assign b_neg = (op == 2'b01) && b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_nxt = {sum, acc[WIDTH-1:1]};
  assign prod    = neg ? (~acc + 1'b1) : acc;

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = RUN;
      RUN: begin
        if (kill)                          nxt = IDLE;
        else if (cnt == CW'(WIDTH - 1))    nxt = FIX;
      end
      FIX:  nxt = kill ? IDLE : DONE;
      DONE: nxt = accept ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      low_sel <= 1'b0;
      result  <= '0;
    end else begin
      if (accept) begin
        mcand   <= a_mag;
        acc     <= {{WIDTH{1'b0}}, b_mag};
        neg     <= a_neg ^ b_neg;
        low_sel <= (op == 2'b00);
        cnt     <= '0;
      end else if (state == RUN && !kill) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !kill)
        result <= low_sel ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit: latency, busy window, the four
// ops at their corner operands, ignored start while busy, back-to-back start,
// kill and asynchronous reset mid-operation.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        busy, done;
  logic [63:0] result;

  int nrun  = 0;
  int nfail = 0;

  mul_unit #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nrun++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge (edge T); returns in cycle T+1.
  task automatic launch(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Steps until done is seen or maxc steps elapse; n = steps taken,
  // nb = cycles with busy high on the way.
  task automatic wait_done(input int maxc, output int n, output int nb);
    n = 0; nb = 0;
    while (!done && n < maxc) begin
      if (busy) nb++;
      step();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] exp);
    int n, nb;
    launch(o, x, y);
    wait_done(200, n, nb);
    chk({tag, " latency"}, 64'(1 + n), 64'd66);
    chk({tag, " busy cycles"}, 64'(nb), 64'd65);
    chk({tag, " result"}, result, exp);
    step();
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) nd++;
      step();
    end
  endtask

  initial begin
    int n, nb, nd;
    reset = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", result, 64'd0);
    step(); step();
    #2 reset = 1'b0;
    step();

    // 3*5 with exact busy window and done-at-T+66
    launch(2'b00, 64'd3, 64'd5);
    wait_done(200, n, nb);
    chk("mul3x5 latency", 64'(1 + n), 64'd66);
    chk("mul3x5 busy cycles", 64'(nb), 64'd65);
    chk("mul3x5 busy at done", 64'(busy), 64'd0);
    chk("mul3x5 result", result, 64'd15);
    step();
    chk("mul3x5 done one cycle", 64'(done), 64'd0);
    count_done(10, nd);
    chk("mul3x5 no extra done", 64'(nd), 64'd0);
    chk("mul3x5 result held", result, 64'd15);

    run_op("mulh -1*-1",  2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    run_op("mulhu max",   2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu -1*max", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulh min*min", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
    run_op("mul min*2",   2'b00, 64'h8000_0000_0000_0000, 64'd2, 64'd0);
    run_op("mulhsu -2*3", 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mul -2*3",    2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA);

    // 7*6, with a second start at T+10 that must be ignored
    launch(2'b00, 64'd7, 64'd6);
    for (int i = 0; i < 9; i++) step();
    a = 64'd9; b = 64'd9; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200, n, nb);
    chk("ignore latency", 64'(11 + n), 64'd66);
    chk("ignore result", result, 64'd42);
    // back-to-back start in the DONE cycle
    launch(2'b00, 64'd9, 64'd9);
    wait_done(200, n, nb);
    chk("b2b latency", 64'(1 + n), 64'd66);
    chk("b2b result", result, 64'd81);
    step();

    // kill at T+30
    launch(2'b00, 64'd5, 64'd5);
    for (int i = 0; i < 29; i++) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill busy", 64'(busy), 64'd0);
    count_done(80, nd);
    chk("kill no done", 64'(nd), 64'd0);
    chk("kill result kept", result, 64'd81);

    // async reset at T+40
    launch(2'b00, 64'd3, 64'd3);
    for (int i = 0; i < 39; i++) step();
    #2 reset = 1'b1;
    #1;
    chk("areset busy", 64'(busy), 64'd0);
    chk("areset done", 64'(done), 64'd0);
    chk("areset result", result, 64'd0);
    #2 reset = 1'b0;
    step();
    count_done(80, nd);
    chk("areset no done", 64'(nd), 64'd0);

    run_op("mul 2x2", 2'b00, 64'd2, 64'd2, 64'd4);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative 64-bit RV64M multiplier in the execute stage. It computes MUL, MULH, MULHSU and MULHU with a radix-2 shift-add datapath and signals `busy` to stall the pipeline. Its registered 64-bit `result` feeds one data input of the writeback-select mux, whose 3-bit select comes from control. A one-cycle `done` pulse tells control to pick that input.

## Interface
- `WIDTH`, 64, operand/result width. Only 64 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a multiply; sampled only when `busy`=0.
- `kill`  in  1  synchronous abort (pipeline flush); overrides `start`.
- `op`  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `a`  in  64  rs1 operand, sampled with an accepted `start`.
- `b`  in  64  rs2 operand, sampled with an accepted `start`.
- `busy`  out  1  high while an operation is in flight (RUN, FIX).
- `done`  out  1  one-cycle pulse: `result` newly valid.
- `result`  out  64  registered result, held until the next completion.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Reset (async, any state):
  - state to IDLE, `busy`=0, `done`=0, `result`=0.
  - counter, accumulator and operand registers cleared.
- Accept: `start`=1 && `kill`=0 in IDLE or DONE. On acceptance, go to RUN and latch:
  - `mcand` = |a| if a is signed (op 01/10) and a[63]=1, else a.
  - `mplier` = |b| if b is signed (op 01) and b[63]=1, else b.
  - `neg` = (a signed & a[63]) XOR (b signed & b[63]).
  - `low_sel` = (op==00).
  - acc(129b) = {1'b0, 64'b0, mplier}; cnt = 0.
- Magnitude: two's-complement negate. 0x8000_0000_0000_0000 maps to itself and is read as unsigned 2^63, which is correct.
- RUN, each cycle:
  - if acc[0]: acc[128:64] = acc[127:64] + mcand, 65-bit sum with carry kept.
  - then acc = acc >> 1 (logical); cnt++.
  - after the 64th iteration (cnt==63 on entry), go to FIX.
- FIX: if `neg`, P = ~acc[127:0] + 1; else P = acc[127:0].
  - op 00: `result` = P[63:0].
  - otherwise: `result` = P[127:64].
  - go to DONE.
- DONE: `done`=1 for exactly this cycle.
  - next state IDLE, or RUN if a new `start` is accepted in this cycle.
- `kill`=1 in RUN or FIX: go to IDLE next edge, `result` unchanged, no `done` pulse.
- `kill` in IDLE/DONE: blocks acceptance that cycle; nothing else changes.
- `start` while `busy`=1: ignored; the in-flight operands are not disturbed.
- `result` changes only at the FIX→DONE edge or on reset.

## Timing
- Accepted `start` sampled at edge T.
- `busy`=1 for cycles T+1 … T+65 (64 RUN + 1 FIX).
- `done`=1 and new `result` visible in cycle T+66; `busy`=0 in that cycle.
- Latency is fixed at 66 cycles, independent of operand values; no early termination.
- Back-to-back: `start` in the DONE cycle (T+66) gives the next `done` at T+132.
- Throughput is one operation per 66 cycles.
- No combinational path from any input to any output.

## Test plan
- Reset, then `op`=00, a=3, b=5, start at T:
  - `busy` high T+1..T+65.
  - `done` pulse at T+66 only.
  - `result`=15, held through 10 idle cycles.
- MULH with a=b=0xFFFF_FFFF_FFFF_FFFF → `result`=0.
- MULHU with a=b=0xFFFF_FFFF_FFFF_FFFF → `result`=0xFFFF_FFFF_FFFF_FFFE.
- MULHSU with a=0xFFFF_FFFF_FFFF_FFFF (−1), b=0xFFFF_FFFF_FFFF_FFFF (unsigned) → `result`=0xFFFF_FFFF_FFFF_FFFF.
- MULH with a=b=0x8000_0000_0000_0000 → `result`=0x4000_0000_0000_0000.
- MUL with a=0x8000_0000_0000_0000, b=2 → `result`=0.
- `start` with a=7, b=6 (op 00), then `start` with a=9, b=9 at T+10 while busy:
  - second `start` ignored; `result`=42 at T+66.
  - then `start` in the DONE cycle → `result`=81 exactly 66 cycles later.
- Abort and reset mid-operation:
  - `kill` at T+30 → `busy`=0 from T+31, no `done`, `result` keeps its previous value.
  - async `reset` at T+40 of a new operation → outputs 0 immediately, no `done` afterwards.
  - next operation 2×2 → 4.
